// File: rtl/cmd_fsm_pkg.sv
// Shared types, fault codes and command-legality helper for the command FSM.
package cmd_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_ARM      = 3'd1,
    CMD_START    = 3'd2,
    CMD_PAUSE    = 3'd3,
    CMD_RESUME   = 3'd4,
    CMD_ABORT    = 3'd5,
    CMD_CLEAR    = 3'd6,
    CMD_RESERVED = 3'd7
  } cmd_e;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_RSVD      = 2'd1;
  localparam logic [1:0] FC_PAUSE_TO  = 2'd2;
  localparam logic [1:0] FC_BAD_STATE = 2'd3;

  // True when the command has a defined meaning in the given state.
  // NOP and RESERVED are meaningful everywhere; illegal state encodings
  // recover to FAULT on their own, so no command is flagged there.
  function automatic logic cmd_legal(input logic [2:0] st, input logic [2:0] c);
    logic ok;
    ok = 1'b0;
    if ((c == CMD_NOP) || (c == CMD_RESERVED)) begin
      ok = 1'b1;
    end else begin
      case (st)
        ST_IDLE:   ok = (c == CMD_ARM);
        ST_ARMED:  ok = (c == CMD_START) || (c == CMD_ABORT);
        ST_RUN:    ok = (c == CMD_PAUSE) || (c == CMD_ABORT);
        ST_PAUSED: ok = (c == CMD_RESUME) || (c == CMD_ABORT);
        ST_DONE:   ok = (c == CMD_CLEAR);
        ST_FAULT:  ok = (c == CMD_CLEAR);
        default:   ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/cmd_fsm_timer.sv
// Loadable up-counter with terminal-count compare, shared by run count and pause timer.
module cmd_fsm_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: load has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (inc) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == tc_val);

endmodule

// File: rtl/cmd_fsm_ctrl.sv
// Command-driven control FSM: IDLE -> ARMED -> RUN -> DONE with pause/resume,
// abort, a timed run phase and defined recovery for every bad encoding.
module cmd_fsm_ctrl
  import cmd_fsm_pkg::*;
#(
  parameter int RUN_CYCLES    = 8,
  parameter int PAUSE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic       cmd_ready,
  output logic [2:0] state_out,
  output logic       busy,
  output logic       done_pulse,
  output logic       cmd_err,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int MAX_CNT = (RUN_CYCLES > PAUSE_TIMEOUT) ? RUN_CYCLES : PAUSE_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  logic [2:0]       state_r, state_nx_s;
  logic             cmd_ready_r, done_r, err_r;
  logic [1:0]       fcode_r, fcode_nx_s;
  logic [CNT_W-1:0] frozen_r, frozen_nx_s;
  logic             done_nx_s, err_nx_s, inc_s, load_s, resume_s, acc_s;
  logic [CNT_W-1:0] cnt_s, tc_val_s, load_val_s;
  logic             tc_s;

  assign acc_s    = cmd_valid && cmd_ready_r;
  // The shared counter times the pause window while PAUSED, the run otherwise.
  assign tc_val_s = (state_r == ST_PAUSED) ? CNT_W'(PAUSE_TIMEOUT - 1) : CNT_W'(RUN_CYCLES - 1);

  cmd_fsm_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .inc      (inc_s),
    .tc_val   (tc_val_s),
    .cnt      (cnt_s),
    .tc       (tc_s)
  );

  // Next-state, counter control and pulse generation.
  always_comb begin
    state_nx_s  = state_r;
    fcode_nx_s  = fcode_r;
    frozen_nx_s = frozen_r;
    done_nx_s   = 1'b0;
    err_nx_s    = 1'b0;
    inc_s       = 1'b0;
    resume_s    = 1'b0;
    if (acc_s && (cmd == CMD_RESERVED)) begin
      state_nx_s = ST_FAULT;
      fcode_nx_s = FC_RSVD;
    end else begin
      err_nx_s = acc_s && !cmd_legal(state_r, cmd);
      case (state_r)
        ST_IDLE: begin
          if (acc_s && (cmd == CMD_ARM)) state_nx_s = ST_IDLE + 3'd1;
          else                           state_nx_s = state_r;
        end
        ST_ARMED: begin
          if (acc_s && (cmd == CMD_START))      state_nx_s = ST_RUN;
          else if (acc_s && (cmd == CMD_ABORT)) state_nx_s = ST_IDLE;
          else                                  state_nx_s = state_r;
        end
        ST_RUN: begin
          if (tc_s) begin
            // Terminal count beats a same-edge PAUSE/ABORT; the loser is flagged.
            state_nx_s = ST_DONE;
            done_nx_s  = 1'b1;
            err_nx_s   = acc_s && (cmd != CMD_NOP);
          end else if (acc_s && (cmd == CMD_PAUSE)) begin
            // This edge completes a run cycle, so it is included in the frozen count.
            state_nx_s  = ST_PAUSED;
            frozen_nx_s = cnt_s + CNT_W'(1);
          end else if (acc_s && (cmd == CMD_ABORT)) begin
            state_nx_s = ST_IDLE;
          end else begin
            inc_s = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (acc_s && (cmd == CMD_RESUME)) begin
            state_nx_s = ST_RUN;
            resume_s   = 1'b1;
          end else if (acc_s && (cmd == CMD_ABORT)) begin
            state_nx_s = ST_IDLE;
          end else if (tc_s) begin
            state_nx_s = ST_FAULT;
            fcode_nx_s = FC_PAUSE_TO;
          end else begin
            inc_s = 1'b1;
          end
        end
        ST_DONE: begin
          if (acc_s && (cmd == CMD_CLEAR)) state_nx_s = ST_IDLE;
          else                             state_nx_s = state_r;
        end
        ST_FAULT: begin
          if (acc_s && (cmd == CMD_CLEAR)) begin
            state_nx_s = ST_IDLE;
            fcode_nx_s = FC_NONE;
          end else begin
            state_nx_s = state_r;
          end
        end
        default: begin
          // Encodings 6/7 (e.g. upset state bits) recover straight to FAULT.
          state_nx_s = ST_FAULT;
          fcode_nx_s = FC_BAD_STATE;
        end
      endcase
    end
    // Every state change restarts the counter; RESUME restores the frozen run count.
    load_s     = (state_nx_s != state_r);
    load_val_s = resume_s ? frozen_r : '0;
  end

  // State, handshake, fault code and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      fcode_r     <= FC_NONE;
      frozen_r    <= '0;
    end else begin
      state_r     <= state_nx_s;
      cmd_ready_r <= !acc_s;
      done_r      <= done_nx_s;
      err_r       <= err_nx_s;
      fcode_r     <= fcode_nx_s;
      frozen_r    <= frozen_nx_s;
    end
  end

  assign state_out  = state_r;
  assign cmd_ready  = cmd_ready_r;
  assign done_pulse = done_r;
  assign cmd_err    = err_r;
  assign fault_code = fcode_r;
  assign busy       = (state_r == ST_ARMED) || (state_r == ST_RUN) || (state_r == ST_PAUSED);
  assign fault      = (state_r == ST_FAULT);

endmodule

// File: tb/tb_cmd_fsm_ctrl.sv
// Directed self-checking bench for cmd_fsm_ctrl (RUN_CYCLES=8, PAUSE_TIMEOUT=16).
module tb_cmd_fsm_ctrl;
  import cmd_fsm_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic [2:0] state_out;
  logic       busy;
  logic       done_pulse;
  logic       cmd_err;
  logic       fault;
  logic [1:0] fault_code;

  int total;
  int bad;

  cmd_fsm_ctrl #(.RUN_CYCLES(8), .PAUSE_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .state_out  (state_out),
    .busy       (busy),
    .done_pulse (done_pulse),
    .cmd_err    (cmd_err),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one command once cmd_ready is seen; returns at the negedge after acceptance.
  task automatic send(input logic [2:0] c);
    int n;
    n = 0;
    while ((cmd_ready !== 1'b1) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd       = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 3'd0;
  endtask

  // Watchdog against any unexpected stall.
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    tick(2);
    check("rst_state", int'(state_out), 0);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_fcode", int'(fault_code), 0);
    check("rst_done",  int'(done_pulse), 0);
    check("rst_err",   int'(cmd_err), 0);
    rst = 1'b0;
    tick(1);
    check("ready_after_rst", int'(cmd_ready), 1);

    // 1: plain run to DONE
    send(CMD_ARM);
    check("t1_armed", int'(state_out), 1);
    check("t1_busy",  int'(busy), 1);
    check("t1_ready_drop", int'(cmd_ready), 0);
    send(CMD_START);
    check("t1_run", int'(state_out), 2);
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("t1_still_run", int'(state_out), 2);
      check("t1_no_done", int'(done_pulse), 0);
    end
    tick(1);
    check("t1_done_state", int'(state_out), 4);
    check("t1_done_pulse", int'(done_pulse), 1);
    check("t1_busy_low",   int'(busy), 0);
    tick(1);
    check("t1_done_single", int'(done_pulse), 0);
    send(CMD_CLEAR);
    check("t1_clear", int'(state_out), 0);

    // 2: run 3, pause 5, resume, 5 more run cycles
    send(CMD_ARM);
    send(CMD_START);
    tick(2);
    send(CMD_PAUSE);
    check("t2_paused", int'(state_out), 3);
    check("t2_busy",   int'(busy), 1);
    tick(4);
    send(CMD_RESUME);
    check("t2_resumed", int'(state_out), 2);
    tick(4);
    check("t2_run_4", int'(state_out), 2);
    tick(1);
    check("t2_done", int'(state_out), 4);
    check("t2_done_pulse", int'(done_pulse), 1);
    check("t2_no_fault", int'(fault), 0);
    send(CMD_CLEAR);

    // 3: pause timeout -> FAULT code 2, illegal ARM, CLEAR
    send(CMD_ARM);
    send(CMD_START);
    send(CMD_PAUSE);
    check("t3_paused", int'(state_out), 3);
    tick(15);
    check("t3_pre_timeout", int'(state_out), 3);
    tick(1);
    check("t3_fault_state", int'(state_out), 5);
    check("t3_fault", int'(fault), 1);
    check("t3_fcode", int'(fault_code), 2);
    send(CMD_ARM);
    check("t3_arm_ignored", int'(state_out), 5);
    check("t3_arm_err", int'(cmd_err), 1);
    tick(1);
    check("t3_err_single", int'(cmd_err), 0);
    send(CMD_CLEAR);
    check("t3_clear_state", int'(state_out), 0);
    check("t3_clear_fcode", int'(fault_code), 0);
    check("t3_clear_fault", int'(fault), 0);

    // 4: RESERVED in ARMED, START in IDLE, back-to-back valid
    send(CMD_ARM);
    send(CMD_RESERVED);
    check("t4_rsvd_state", int'(state_out), 5);
    check("t4_rsvd_fcode", int'(fault_code), 1);
    check("t4_rsvd_no_err", int'(cmd_err), 0);
    send(CMD_CLEAR);
    send(CMD_START);
    check("t4_start_idle_state", int'(state_out), 0);
    check("t4_start_idle_err", int'(cmd_err), 1);
    tick(1);
    check("t4_ready_before_b2b", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd       = CMD_NOP;
    tick(1);
    check("t4_b2b_0", int'(cmd_ready), 0);
    tick(1);
    check("t4_b2b_1", int'(cmd_ready), 1);
    tick(1);
    check("t4_b2b_2", int'(cmd_ready), 0);
    tick(1);
    check("t4_b2b_3", int'(cmd_ready), 1);
    check("t4_nop_no_err", int'(cmd_err), 0);
    check("t4_nop_state", int'(state_out), 0);
    cmd_valid = 1'b0;
    tick(1);

    // 5: illegal state encoding, then reset mid-RUN
    force dut.state_r = 3'd6;
    #1;
    release dut.state_r;
    check("t5_forced", int'(state_out), 6);
    tick(1);
    check("t5_bad_state_fault", int'(state_out), 5);
    check("t5_bad_state_fcode", int'(fault_code), 3);
    send(CMD_CLEAR);
    check("t5_clear", int'(state_out), 0);
    send(CMD_ARM);
    send(CMD_START);
    tick(3);
    check("t5_mid_run", int'(state_out), 2);
    rst = 1'b1;
    tick(1);
    check("t5_rst_state", int'(state_out), 0);
    check("t5_rst_ready", int'(cmd_ready), 0);
    tick(1);
    check("t5_rst_ready_hold", int'(cmd_ready), 0);
    rst = 1'b0;
    tick(1);
    check("t5_ready_back", int'(cmd_ready), 1);

    // 6: PAUSE on terminal cycle, RESUME on timeout cycle
    send(CMD_ARM);
    send(CMD_START);
    tick(7);
    send(CMD_PAUSE);
    check("t6_term_state", int'(state_out), 4);
    check("t6_term_done", int'(done_pulse), 1);
    check("t6_term_err", int'(cmd_err), 1);
    send(CMD_CLEAR);
    send(CMD_ARM);
    send(CMD_START);
    send(CMD_PAUSE);
    tick(15);
    send(CMD_RESUME);
    check("t6_resume_state", int'(state_out), 2);
    check("t6_resume_nofault", int'(fault), 0);
    check("t6_resume_fcode", int'(fault_code), 0);
    tick(5);
    check("t6_run_rest", int'(state_out), 2);
    tick(1);
    check("t6_done_after_resume", int'(state_out), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
